// File: rtl/orbtrace_cmd_pkg.sv
// Shared opcodes, acknowledge codes and decoder state encoding for the host command decoder.
// The CSUM state exists only when CMD_CHECKSUM_EN is defined.
package orbtrace_cmd_pkg;

  localparam logic [7:0] CMD_SET_WIDTH     = 8'h01;
  localparam logic [7:0] CMD_TRACE_EN      = 8'h02;
  localparam logic [7:0] CMD_STATUS        = 8'h03;
  localparam logic [7:0] ACK_OK_MASK       = 8'h80;
  localparam logic [7:0] ACK_ERR           = 8'hEE;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_ARG, ST_CSUM} dec_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_ARG} dec_state_e;
`endif

  function automatic logic width_legal(input logic [7:0] arg);
    return (arg == 8'd1) || (arg == 8'd2) || (arg == 8'd4);
  endfunction

endpackage

// File: rtl/cmd_decoder_rx_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while a frame is open and strobes
// o_expired on the cycle the gap reaches TIMEOUT_CYCLES.
module rx_gap_timer #(
  parameter int TIMEOUT_CYCLES = 480_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_expired;

  assign w_expired = i_run && !i_clear && (r_count == LAST);
  assign o_expired = w_expired;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || !i_run || w_expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/cmd_decoder.sv
// Host command decoder: parses SYNC/CMD/ARG[/CSUM] frames from the UART and drives trace config
// plus a single-entry acknowledge register. CMD_CHECKSUM_EN selects the 4-byte checksummed frame.
module cmd_decoder
  import orbtrace_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 480_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rxByte,
  input  logic       rxTrig,
  input  logic       rxErr,
  output logic [2:0] width,
  output logic       traceEn,
  output logic       cmdValid,
  output logic       cmdErr,
  output logic [7:0] errCount,
  output logic       ackAvail,
  output logic [7:0] ackByte,
  input  logic       ackNext
);

  dec_state_e r_state, w_state_nxt;
  logic [7:0] r_cmd, w_cmd_nxt;
`ifdef CMD_CHECKSUM_EN
  logic [7:0] r_arg, w_arg_nxt;
`endif
  logic [2:0] r_width, w_width_nxt;
  logic       r_trace_en, w_trace_en_nxt;
  logic       r_cmd_valid, r_cmd_err;
  logic [7:0] r_err_count, w_err_count_nxt;
  logic       r_ack_avail, w_ack_avail_nxt;
  logic [7:0] r_ack_byte, w_ack_byte_nxt;

  logic       w_expired, w_final, w_csum_ok, w_err_abort, w_cmd_ok, w_reject, w_ack_load;
  logic [7:0] w_fin_arg, w_ack_val;

  rx_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (rxTrig),
    .i_run     (r_state != ST_IDLE),
    .o_expired (w_expired)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
`ifdef CMD_CHECKSUM_EN
    w_arg_nxt   = r_arg;
`endif
    w_final     = 1'b0;
    w_fin_arg   = rxByte;
    w_csum_ok   = 1'b1;

    case (r_state)
      ST_IDLE: if (rxTrig && rxByte == SYNC_BYTE) w_state_nxt = ST_CMD;
      ST_CMD: if (rxTrig) begin
        w_cmd_nxt   = rxByte;
        w_state_nxt = ST_ARG;
      end
`ifdef CMD_CHECKSUM_EN
      ST_ARG: if (rxTrig) begin
        w_arg_nxt   = rxByte;
        w_state_nxt = ST_CSUM;
      end
      ST_CSUM: if (rxTrig) begin
        w_final     = 1'b1;
        w_fin_arg   = r_arg;
        w_csum_ok   = (rxByte == (r_cmd ^ r_arg));
        w_state_nxt = ST_IDLE;
      end
`else
      ST_ARG: if (rxTrig) begin
        w_final     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    // A UART error or gap timeout aborts the open frame, even if a byte arrives alongside.
    w_err_abort = (r_state != ST_IDLE) && rxErr;
    if (w_err_abort || w_expired) begin
      w_state_nxt = ST_IDLE;
      w_final     = 1'b0;
    end

    w_cmd_ok       = 1'b0;
    w_ack_val      = ACK_ERR;
    w_width_nxt    = r_width;
    w_trace_en_nxt = r_trace_en;
    if (w_final && w_csum_ok) begin
      case (r_cmd)
        CMD_SET_WIDTH: if (width_legal(w_fin_arg)) begin
          w_cmd_ok    = 1'b1;
          w_width_nxt = w_fin_arg[2:0];
          w_ack_val   = CMD_SET_WIDTH | ACK_OK_MASK;
        end
        CMD_TRACE_EN: begin
          w_cmd_ok       = 1'b1;
          w_trace_en_nxt = w_fin_arg[0];
          w_ack_val      = CMD_TRACE_EN | ACK_OK_MASK;
        end
        CMD_STATUS: begin
          w_cmd_ok  = 1'b1;
          w_ack_val = {3'b000, r_trace_en, 1'b0, r_width};
        end
        default: w_cmd_ok = 1'b0;
      endcase
    end

    w_reject        = (w_final && !w_cmd_ok) || w_err_abort || w_expired;
    w_ack_load      = w_final || w_err_abort;
    w_err_count_nxt = (w_reject && r_err_count != 8'hFF) ? r_err_count + 8'd1 : r_err_count;

    // A fresh load beats a simultaneous pop so the new byte is never lost.
    w_ack_avail_nxt = r_ack_avail;
    w_ack_byte_nxt  = r_ack_byte;
    if (w_ack_load) begin
      w_ack_avail_nxt = 1'b1;
      w_ack_byte_nxt  = w_ack_val;
    end else if (ackNext) begin
      w_ack_avail_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cmd       <= 8'h00;
`ifdef CMD_CHECKSUM_EN
      r_arg       <= 8'h00;
`endif
      r_width     <= 3'd1;
      r_trace_en  <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_err_count <= 8'h00;
      r_ack_avail <= 1'b0;
      r_ack_byte  <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
`ifdef CMD_CHECKSUM_EN
      r_arg       <= w_arg_nxt;
`endif
      r_width     <= w_width_nxt;
      r_trace_en  <= w_trace_en_nxt;
      r_cmd_valid <= w_cmd_ok;
      r_cmd_err   <= w_reject;
      r_err_count <= w_err_count_nxt;
      r_ack_avail <= w_ack_avail_nxt;
      r_ack_byte  <= w_ack_byte_nxt;
    end
  end

  assign width    = r_width;
  assign traceEn  = r_trace_en;
  assign cmdValid = r_cmd_valid;
  assign cmdErr   = r_cmd_err;
  assign errCount = r_err_count;
  assign ackAvail = r_ack_avail;
  assign ackByte  = r_ack_byte;

endmodule
